// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   memStateT       : access FSM states (IDLE / BUSY / DONE)
//   MEM_*_BIT       : bit positions inside the EX_MEM M control field {memRead, memWrite}
//   WB_*_BIT        : bit positions inside the WB control field {regWrite, memToReg}
//   isWordAligned() : true when a byte address is on a word boundary
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } memStateT;

  localparam int MEM_READ_BIT    = 1;
  localparam int MEM_WRITE_BIT   = 0;
  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;

  function automatic logic isWordAligned(input logic [1:0] addrLsb);
    return addrLsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Cycle counter that bounds how long a memory access may stay outstanding.
// Ports:
//   clock    in  pipeline clock
//   reset    in  asynchronous, active-high
//   clear    in  synchronous clear to zero (takes priority over enable)
//   enable   in  count up by one this cycle
//   terminal out high while the count equals TIMEOUT-1
module mem_timeout_counter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_W-1:0] count;

  // NOTE: clocked state is assigned with non-blocking (<=) only, so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage pipeline, between EX_MEM and MEM_WB.
// Issues one request per load/store on a req/ready data-memory port, stalls the
// upstream pipeline while the access is outstanding, rejects misaligned
// addresses and aborts accesses that exceed TIMEOUT busy cycles.
// Ports:
//   clock, reset             pipeline clock; asynchronous active-high reset
//   aluResult/writeData/rd   EX_MEM payload (byte address, store data, dest reg)
//   wbIn, mIn                EX_MEM control: {regWrite,memToReg}, {memRead,memWrite}
//   readMemoryWord/readALU/readRD/wbOut   MEM_WB inputs
//   stall                    freeze upstream registers, bubble MEM_WB
//   memReq/memWe/memAddr/memWdata/memRdata/memReady   data-memory port
//   misaligned               one-cycle flag for a rejected misaligned access
//   busError                 sticky timeout flag, cleared only by reset
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] aluResult,
  input  logic [DATA_W-1:0] writeData,
  input  logic [4:0]        rd,
  input  logic [1:0]        wbIn,
  input  logic [1:0]        mIn,
  output logic [DATA_W-1:0] readMemoryWord,
  output logic [ADDR_W-1:0] readALU,
  output logic [4:0]        readRD,
  output logic [1:0]        wbOut,
  output logic              stall,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memReady,
  output logic              misaligned,
  output logic              busError
);

  memStateT          state, nextState;
  logic [DATA_W-1:0] rdataReg;
  logic              aborted;      // current access ended by timeout
  logic              timeoutHit;

  // Both control bits set is treated as a store.
  logic op, isStore, aligned, startAccess;
  assign op          = mIn[MEM_READ_BIT] | mIn[MEM_WRITE_BIT];
  assign isStore     = mIn[MEM_WRITE_BIT];
  assign aligned     = isWordAligned(aluResult[1:0]);
  assign startAccess = (state == IDLE) && op && aligned;

  mem_timeout_counter #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) timeoutCounter (
    .clock   (clock),
    .reset   (reset),
    .clear   (state != BUSY),
    .enable  (state == BUSY),
    .terminal(timeoutHit)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic. memReady is only meaningful in BUSY and wins over timeout.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (startAccess) nextState = BUSY;
      BUSY:    if (memReady || timeoutHit) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Memory port and response registers; request fields are captured once on
  // entry to BUSY so they stay stable for the whole access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      rdataReg <= '0;
      busError <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (startAccess) begin
            memReq   <= 1'b1;
            memWe    <= isStore;
            memAddr  <= {aluResult[ADDR_W-1:2], 2'b00};
            memWdata <= writeData;
            aborted  <= 1'b0;
          end
        end
        BUSY: begin
          if (memReady) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            rdataReg <= memWe ? '0 : memRdata;  // store responses are discarded
          end else if (timeoutHit) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            rdataReg <= '0;
            busError <= 1'b1;
            aborted  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic. Reset forces stall/misaligned low even while an op is still
  // presented by the frozen EX_MEM register.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    stall          = 1'b0;
    misaligned     = 1'b0;
    wbOut          = wbIn;
    readMemoryWord = '0;
    unique case (state)
      IDLE: begin
        if (op) begin
          if (aligned) begin
            stall = 1'b1;
          end else begin
            misaligned = 1'b1;
            wbOut      = 2'b00;
          end
        end
      end
      BUSY: stall = 1'b1;
      DONE: begin
        readMemoryWord = rdataReg;
        if (aborted) wbOut = 2'b00;
      end
      default: ;
    endcase
    if (reset) begin
      stall      = 1'b0;
      misaligned = 1'b0;
    end
  end

  assign readALU = aluResult;
  assign readRD  = rd;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] aluResult, writeData;
  logic [4:0]  rd;
  logic [1:0]  wbIn, mIn;
  logic [31:0] readMemoryWord, readALU;
  logic [4:0]  readRD;
  logic [1:0]  wbOut;
  logic        stall, memReq, memWe;
  logic [31:0] memAddr, memWdata, memRdata;
  logic        memReady, misaligned, busError;

  always #5 clock = ~clock;

  mem_access_stage #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .aluResult(aluResult), .writeData(writeData),
    .rd(rd), .wbIn(wbIn), .mIn(mIn), .readMemoryWord(readMemoryWord),
    .readALU(readALU), .readRD(readRD), .wbOut(wbOut), .stall(stall),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memReady(memReady), .misaligned(misaligned),
    .busError(busError)
  );

  typedef struct {
    logic [31:0] rmw;
    logic [1:0]  wb;
    logic        err;
    logic        mis;
    int          stallCycles;
    int          reqCycles;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } expT;

  typedef struct {
    logic [31:0] rmw;
    logic [1:0]  wb;
    logic        err;
    logic        mis;
    int          stallCycles;
    int          reqCycles;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        unstable;
    logic        done;
  } obsT;

  expT expQ[$];
  int checks   = 0;
  int failures = 0;

  // Memory responder: raises memReady in the respLat-th cycle memReq is high
  // (respLat==0 means never); spurious forces memReady outside any request.
  int          respLat  = 0;
  logic [31:0] respData = '0;
  logic        spurious = 1'b0;

  initial begin
    int busyCnt;
    busyCnt  = 0;
    memReady = 1'b0;
    memRdata = '0;
    forever begin
      @(negedge clock);
      if (memReq) busyCnt++;
      else        busyCnt = 0;
      memReady = spurious || (memReq && respLat != 0 && busyCnt == respLat);
      memRdata = memReady ? respData : $urandom;
    end
  end

  // Presents one EX_MEM instruction and watches it until stall drops.
  task automatic runAccess(input logic [1:0] m, input logic [31:0] addr,
                           input logic [31:0] data, input logic [4:0] r,
                           input logic [1:0] wb, input int lat,
                           input logic [31:0] rdat, output obsT o);
    @(negedge clock);
    respLat = lat; respData = rdat;
    mIn = m; aluResult = addr; writeData = data; rd = r; wbIn = wb;
    o = '{default: 0};
    for (int cyc = 0; cyc < 100; cyc++) begin
      #1;
      if (memReq) begin
        if (o.reqCycles == 0) begin
          o.we = memWe; o.addr = memAddr; o.wdata = memWdata;
        end else if (memWe !== o.we || memAddr !== o.addr || memWdata !== o.wdata) begin
          o.unstable = 1'b1;
        end
        o.reqCycles++;
      end
      if (stall !== 1'b1) begin
        o.rmw = readMemoryWord; o.wb = wbOut; o.err = busError; o.mis = misaligned;
        o.done = 1'b1;
        break;
      end
      o.stallCycles++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mIn = 2'b00; aluResult = '0; writeData = '0; rd = '0; wbIn = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({memReq, memWe, stall, misaligned, busError} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got {req,we,stall,mis,err}=%b expected 00000",
               {memReq, memWe, stall, misaligned, busError});
    end
    checks++;
    if (readMemoryWord !== 32'h0) begin
      failures++;
      $display("FAIL reset_rmw: got %h expected 00000000", readMemoryWord);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_passthrough();
    logic sawStall, sawReq;
    sawStall = 1'b0; sawReq = 1'b0;
    spurious = 1'b1;
    @(negedge clock);
    mIn = 2'b00; aluResult = 32'h10; rd = 5'd5; wbIn = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (stall !== 1'b0) sawStall = 1'b1;
      if (memReq !== 1'b0) sawReq = 1'b1;
      @(negedge clock);
    end
    spurious = 1'b0;
    checks++;
    if (sawStall) begin failures++; $display("FAIL idle_stall: stall rose, expected 0"); end
    checks++;
    if (sawReq) begin failures++; $display("FAIL idle_req: memReq rose, expected 0"); end
    checks++;
    if (readALU !== 32'h10) begin
      failures++; $display("FAIL idle_readALU: got %h expected 00000010", readALU);
    end
    checks++;
    if (readRD !== 5'd5) begin
      failures++; $display("FAIL idle_readRD: got %0d expected 5", readRD);
    end
    checks++;
    if (wbOut !== 2'b10) begin
      failures++; $display("FAIL idle_wbOut: got %b expected 10", wbOut);
    end
  endtask

  task automatic test_load_fast();
    obsT o; expT e;
    expQ.push_back('{rmw: 32'hDEADBEEF, wb: 2'b11, err: 1'b0, mis: 1'b0, stallCycles: 2,
                     reqCycles: 1, we: 1'b0, addr: 32'h40, wdata: 32'h0});
    runAccess(2'b10, 32'h40, 32'h0, 5'd7, 2'b11, 1, 32'hDEADBEEF, o);
    e = expQ.pop_front();
    checks++;
    if (!o.done) begin failures++; $display("FAIL load_fast_done: no completion within bound"); end
    checks++;
    if (o.rmw !== e.rmw) begin
      failures++; $display("FAIL load_fast_rmw: got %h expected %h", o.rmw, e.rmw);
    end
    checks++;
    if (o.stallCycles != e.stallCycles) begin
      failures++; $display("FAIL load_fast_stall: got %0d expected %0d", o.stallCycles, e.stallCycles);
    end
    checks++;
    if (o.addr !== e.addr || o.we !== e.we || o.reqCycles != e.reqCycles) begin
      failures++;
      $display("FAIL load_fast_req: got addr=%h we=%b req=%0d expected addr=%h we=%b req=%0d",
               o.addr, o.we, o.reqCycles, e.addr, e.we, e.reqCycles);
    end
    checks++;
    if (o.wb !== e.wb || o.err !== e.err) begin
      failures++;
      $display("FAIL load_fast_wb: got wb=%b err=%b expected wb=%b err=%b", o.wb, o.err, e.wb, e.err);
    end
  endtask

  task automatic test_store_slow();
    obsT o; expT e;
    expQ.push_back('{rmw: 32'h0, wb: 2'b00, err: 1'b0, mis: 1'b0, stallCycles: 5,
                     reqCycles: 4, we: 1'b1, addr: 32'h80, wdata: 32'h1234});
    runAccess(2'b01, 32'h80, 32'h1234, 5'd0, 2'b00, 4, 32'hFFFF_FFFF, o);
    e = expQ.pop_front();
    checks++;
    if (!o.done) begin failures++; $display("FAIL store_done: no completion within bound"); end
    checks++;
    if (o.we !== e.we || o.wdata !== e.wdata || o.addr !== e.addr) begin
      failures++;
      $display("FAIL store_req: got we=%b wdata=%h addr=%h expected we=%b wdata=%h addr=%h",
               o.we, o.wdata, o.addr, e.we, e.wdata, e.addr);
    end
    checks++;
    if (o.reqCycles != e.reqCycles || o.unstable) begin
      failures++;
      $display("FAIL store_hold: got req=%0d unstable=%b expected req=%0d unstable=0",
               o.reqCycles, o.unstable, e.reqCycles);
    end
    checks++;
    if (o.stallCycles != e.stallCycles) begin
      failures++; $display("FAIL store_stall: got %0d expected %0d", o.stallCycles, e.stallCycles);
    end
    checks++;
    if (o.err !== e.err) begin
      failures++; $display("FAIL store_err: got %b expected %b", o.err, e.err);
    end
  endtask

  task automatic test_misaligned();
    obsT o; expT e;
    expQ.push_back('{rmw: 32'h0, wb: 2'b00, err: 1'b0, mis: 1'b1, stallCycles: 0,
                     reqCycles: 0, we: 1'b0, addr: 32'h0, wdata: 32'h0});
    runAccess(2'b10, 32'h42, 32'h0, 5'd9, 2'b11, 1, 32'h0, o);
    e = expQ.pop_front();
    checks++;
    if (o.mis !== e.mis || o.wb !== e.wb || o.stallCycles != e.stallCycles) begin
      failures++;
      $display("FAIL misaligned_flag: got mis=%b wb=%b stall=%0d expected mis=%b wb=%b stall=%0d",
               o.mis, o.wb, o.stallCycles, e.mis, e.wb, e.stallCycles);
    end
    @(negedge clock);
    mIn = 2'b00;
    #1;
    checks++;
    if (memReq !== 1'b0 || misaligned !== 1'b0 || o.reqCycles != e.reqCycles) begin
      failures++;
      $display("FAIL misaligned_after: got req=%b mis=%b reqCycles=%0d expected 0 0 0",
               memReq, misaligned, o.reqCycles);
    end
  endtask

  task automatic test_back_to_back();
    obsT o1, o2; expT e;
    expQ.push_back('{rmw: 32'h11112222, wb: 2'b11, err: 1'b0, mis: 1'b0, stallCycles: 3,
                     reqCycles: 2, we: 1'b0, addr: 32'h104, wdata: 32'h0});
    expQ.push_back('{rmw: 32'h33334444, wb: 2'b11, err: 1'b0, mis: 1'b0, stallCycles: 4,
                     reqCycles: 3, we: 1'b0, addr: 32'h208, wdata: 32'h0});
    runAccess(2'b10, 32'h104, 32'h0, 5'd1, 2'b11, 2, 32'h11112222, o1);
    runAccess(2'b10, 32'h208, 32'h0, 5'd2, 2'b11, 3, 32'h33334444, o2);
    e = expQ.pop_front();
    checks++;
    if (o1.rmw !== e.rmw || o1.stallCycles != e.stallCycles || o1.addr !== e.addr) begin
      failures++;
      $display("FAIL b2b_first: got rmw=%h stall=%0d addr=%h expected rmw=%h stall=%0d addr=%h",
               o1.rmw, o1.stallCycles, o1.addr, e.rmw, e.stallCycles, e.addr);
    end
    e = expQ.pop_front();
    checks++;
    if (o2.rmw !== e.rmw || o2.stallCycles != e.stallCycles || o2.addr !== e.addr) begin
      failures++;
      $display("FAIL b2b_second: got rmw=%h stall=%0d addr=%h expected rmw=%h stall=%0d addr=%h",
               o2.rmw, o2.stallCycles, o2.addr, e.rmw, e.stallCycles, e.addr);
    end
  endtask

  task automatic test_timeout();
    obsT o; expT e;
    expQ.push_back('{rmw: 32'h0, wb: 2'b00, err: 1'b1, mis: 1'b0, stallCycles: 17,
                     reqCycles: 16, we: 1'b0, addr: 32'h300, wdata: 32'h0});
    runAccess(2'b10, 32'h300, 32'h0, 5'd3, 2'b11, 0, 32'h0, o);
    e = expQ.pop_front();
    checks++;
    if (o.reqCycles != e.reqCycles || o.stallCycles != e.stallCycles) begin
      failures++;
      $display("FAIL timeout_len: got req=%0d stall=%0d expected req=%0d stall=%0d",
               o.reqCycles, o.stallCycles, e.reqCycles, e.stallCycles);
    end
    checks++;
    if (o.rmw !== e.rmw || o.wb !== e.wb || o.err !== e.err) begin
      failures++;
      $display("FAIL timeout_out: got rmw=%h wb=%b err=%b expected rmw=%h wb=%b err=%b",
               o.rmw, o.wb, o.err, e.rmw, e.wb, e.err);
    end
    @(negedge clock);
    mIn = 2'b00;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (busError !== 1'b1) begin
      failures++; $display("FAIL timeout_sticky: got busError=%b expected 1", busError);
    end
    expQ.push_back('{rmw: 32'hCAFEF00D, wb: 2'b11, err: 1'b1, mis: 1'b0, stallCycles: 3,
                     reqCycles: 2, we: 1'b0, addr: 32'h304, wdata: 32'h0});
    runAccess(2'b10, 32'h304, 32'h0, 5'd4, 2'b11, 2, 32'hCAFEF00D, o);
    e = expQ.pop_front();
    checks++;
    if (o.rmw !== e.rmw || o.wb !== e.wb || o.err !== e.err) begin
      failures++;
      $display("FAIL timeout_recover: got rmw=%h wb=%b err=%b expected rmw=%h wb=%b err=%b",
               o.rmw, o.wb, o.err, e.rmw, e.wb, e.err);
    end
  endtask

  task automatic test_reset_mid_busy();
    obsT o; expT e;
    @(negedge clock);
    respLat = 10; mIn = 2'b10; aluResult = 32'h400; rd = 5'd6; wbIn = 2'b11;
    repeat (2) @(negedge clock);
    #2;
    checks++;
    if (memReq !== 1'b1) begin
      failures++; $display("FAIL rst_busy_pre: got memReq=%b expected 1", memReq);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (memReq !== 1'b0 || stall !== 1'b0 || busError !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy_drop: got req=%b stall=%b err=%b expected 0 0 0",
               memReq, stall, busError);
    end
    @(negedge clock);
    reset = 1'b0; mIn = 2'b00;
    expQ.push_back('{rmw: 32'h55AA55AA, wb: 2'b11, err: 1'b0, mis: 1'b0, stallCycles: 3,
                     reqCycles: 2, we: 1'b0, addr: 32'h400, wdata: 32'h0});
    runAccess(2'b10, 32'h400, 32'h0, 5'd6, 2'b11, 2, 32'h55AA55AA, o);
    e = expQ.pop_front();
    checks++;
    if (o.rmw !== e.rmw || o.stallCycles != e.stallCycles || o.err !== e.err || o.wb !== e.wb) begin
      failures++;
      $display("FAIL rst_busy_fresh: got rmw=%h stall=%0d err=%b wb=%b expected rmw=%h stall=%0d err=%b wb=%b",
               o.rmw, o.stallCycles, o.err, o.wb, e.rmw, e.stallCycles, e.err, e.wb);
    end
    @(negedge clock);
    mIn = 2'b00;
  endtask

  initial begin
    test_reset();
    test_idle_passthrough();
    test_load_fast();
    test_store_slow();
    test_misaligned();
    test_back_to_back();
    test_timeout();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
